// File: rtl/serial_adder_seq_if.sv
// Start/done request interface of the bit-serial adder sequencer.
// The requester drives operands and start; the sequencer returns status and result.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first,
// with the carry held in a flip-flop between slices.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_adder_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opb, res, res_nx, sum_q;
    logic             carry, cout_q;
    logic [CW-1:0]    cnt;
    logic             af, bf, cf, fa_sum, fa_carry;
    logic             last;

    // Full-adder slice (af/bf/cf -> sum/carry) applied to the current LSBs.
    always_comb begin
        af       = opa[0];
        bf       = opb[0];
        cf       = carry;
        fa_sum   = af ^ bf ^ cf;
        fa_carry = (af & bf) | (cf & (af ^ bf));
    end

    assign last = (cnt == CW'(WIDTH - 1));

    // Written as shift-then-set so WIDTH == 1 needs no special slicing.
    always_comb begin
        res_nx            = res >> 1;
        res_nx[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa   <= bus.a;
                        opb   <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    res   <= res_nx;
                    carry <= fa_carry;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum_q  <= res_nx;
                        cout_q <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq at WIDTH = 1, 8 and 16 against a timing/arithmetic model.
module tb_serial_adder_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        st[3], ci[3];
    logic [15:0] av[3], bv[3];
    logic        bz[3], dn[3], co[3];
    logic [15:0] sm[3];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    serial_adder_seq_if #(.WIDTH(1))  i0 ();
    serial_adder_seq_if #(.WIDTH(8))  i1 ();
    serial_adder_seq_if #(.WIDTH(16)) i2 ();

    serial_adder_seq #(.WIDTH(1))  u0 (.clk(clk), .rst(rst), .bus(i0));
    serial_adder_seq #(.WIDTH(8))  u1 (.clk(clk), .rst(rst), .bus(i1));
    serial_adder_seq #(.WIDTH(16)) u2 (.clk(clk), .rst(rst), .bus(i2));

    assign i0.start = st[0]; assign i0.a = av[0][0:0]; assign i0.b = bv[0][0:0]; assign i0.cin = ci[0];
    assign i1.start = st[1]; assign i1.a = av[1][7:0]; assign i1.b = bv[1][7:0]; assign i1.cin = ci[1];
    assign i2.start = st[2]; assign i2.a = av[2];      assign i2.b = bv[2];      assign i2.cin = ci[2];
    assign bz[0] = i0.busy; assign dn[0] = i0.done; assign co[0] = i0.cout; assign sm[0] = 16'(i0.sum);
    assign bz[1] = i1.busy; assign dn[1] = i1.done; assign co[1] = i1.cout; assign sm[1] = 16'(i1.sum);
    assign bz[2] = i2.busy; assign dn[2] = i2.done; assign co[2] = i2.cout; assign sm[2] = i2.sum;

    function automatic int wof(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 8 : 16);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation accepted at edge t0 keeps busy for the WIDTH cycles after it,
    // publishes a+b+cin at edge t0+WIDTH, pulses done after that edge, and is idle again
    // from edge t0+WIDTH+2.
    bit          act[3] = '{0, 0, 0};
    longint      t0[3];
    longint      cyc = 0;
    int unsigned pend_s[3], pend_c[3];
    int unsigned exp_s[3] = '{0, 0, 0};
    int unsigned exp_c[3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            int          w;
            int unsigned mask, tot;
            w    = wof(k);
            mask = (32'd1 << w) - 1;
            if (rst) begin
                act[k]   = 1'b0;
                exp_s[k] = 0;
                exp_c[k] = 0;
            end else begin
                if (act[k] && (cyc - t0[k] == longint'(w))) begin
                    exp_s[k] = pend_s[k];
                    exp_c[k] = pend_c[k];
                end
                if (act[k] && (cyc - t0[k] >= longint'(w + 2))) act[k] = 1'b0;
                if (!act[k] && st[k] === 1'b1) begin
                    tot       = (32'(av[k]) & mask) + (32'(bv[k]) & mask) + 32'(ci[k]);
                    pend_s[k] = tot & mask;
                    pend_c[k] = (tot >> w) & 1;
                    act[k]    = 1'b1;
                    t0[k]     = cyc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int k = 0; k < 3; k++) begin
                longint d;
                logic   eb, ed;
                d  = cyc - t0[k];
                eb = act[k] && (d >= 0) && (d < longint'(wof(k)));
                ed = act[k] && (d == longint'(wof(k)));
                chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(eb));
                chk($sformatf("done%0d", k), 32'(dn[k]), 32'(ed));
                chk($sformatf("sum%0d", k),  32'(sm[k]), exp_s[k]);
                chk($sformatf("cout%0d", k), 32'(co[k]), exp_c[k]);
            end
        end
    end

    task automatic wait_done(input int k);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dn[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("done_seen%0d", k), 32'(seen), 32'd1);
    endtask

    task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
        @(posedge clk); #1;
        st[k] = 1'b1; av[k] = a; bv[k] = b; ci[k] = c;
        @(posedge clk); #1;
        st[k] = 1'b0; av[k] = 16'($urandom); bv[k] = 16'($urandom); ci[k] = 1'($urandom);
        wait_done(k);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; ci[k] = 1'b0; av[k] = '0; bv[k] = '0;
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy%0d", k), 32'(bz[k]), 32'd0);
            chk($sformatf("rst_done%0d", k), 32'(dn[k]), 32'd0);
            chk($sformatf("rst_sum%0d", k),  32'(sm[k]), 32'd0);
            chk($sformatf("rst_cout%0d", k), 32'(co[k]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        op(1, 16'h00FF, 16'h0001, 1'b0);
        chk("ff_01_sum", 32'(sm[1]), 32'h00);
        chk("ff_01_cout", 32'(co[1]), 32'd1);
        op(1, 16'h005A, 16'h00A5, 1'b1);
        chk("5a_a5_sum", 32'(sm[1]), 32'h00);
        chk("5a_a5_cout", 32'(co[1]), 32'd1);
        op(1, 16'h0012, 16'h0034, 1'b0);
        chk("12_34_sum", 32'(sm[1]), 32'h46);
        chk("12_34_cout", 32'(co[1]), 32'd0);

        // start held high across RUN while operands change underneath
        @(posedge clk); #1;
        st[1] = 1'b1; av[1] = 16'h000F; bv[1] = 16'h0001; ci[1] = 1'b0;
        @(posedge clk); #1;
        av[1] = 16'h00C3; bv[1] = 16'h007E; ci[1] = 1'b1;
        wait_done(1);
        st[1] = 1'b0;
        chk("hold_sum", 32'(sm[1]), 32'h10);
        chk("hold_cout", 32'(co[1]), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_idle", 32'(bz[1]), 32'd0);

        // reset three cycles into RUN
        @(posedge clk); #1;
        st[1] = 1'b1; av[1] = 16'h000F; bv[1] = 16'h0001; ci[1] = 1'b0;
        @(posedge clk); #1;
        st[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_sum", 32'(sm[1]), 32'd0);
        chk("abort_cout", 32'(co[1]), 32'd0);
        chk("abort_busy", 32'(bz[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op(1, 16'h000F, 16'h0001, 1'b0);
        chk("after_abort_sum", 32'(sm[1]), 32'h10);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op(0, 16'(v[2]), 16'(v[1]), v[0]);
            chk($sformatf("w1_%0d", i), {30'd0, co[0], sm[0][0]}, 32'(v[2]) + 32'(v[1]) + 32'(v[0]));
        end

        fork
            for (int n = 0; n < 500; n++) op(1, 16'($urandom), 16'($urandom), 1'($urandom));
            for (int n = 0; n < 500; n++) op(2, 16'($urandom), 16'($urandom), 1'($urandom));
            for (int n = 0; n < 100; n++) op(0, 16'($urandom), 16'($urandom), 1'($urandom));
        join

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
